pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage core, sitting beside the instruction decoder. It watches the decoded ID-stage instruction (register reads, destination, load flag, branch result, exception code) and generates IF/ID stall, flush and PC-redirect controls. It resolves load-use hazards with a one-cycle bubble, redirects on taken branches and jumps, and runs an exception drain/trap sequence. It is the only source of pipeline stall/flush and PC redirect.

## Interface
- `DRAIN_CYCLES`, 3: cycles spent draining older instructions (EX/MEM/WB) before trapping; legal range 1..15.
- `TRAP_VEC`, 0: word address loaded into PC on trap.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_en`  in  1  ID stage holds a valid instruction.
- `id_pc`  in  `WORD_ADDR_BUS`  word address of ID instruction.
- `id_rs0_addr`, `id_rs1_addr`  in  5 each  source register addresses.
- `id_rs0_used`, `id_rs1_used`  in  1 each  source actually read by this instruction.
- `id_dst_addr`  in  5  destination register.
- `id_gpr_we_`  in  1  active-low GPR write enable.
- `id_mem_load`  in  1  instruction is a load (any LW/LH/LHU/LB/LBU).
- `id_br_taken`  in  1  branch/jump taken.
- `id_br_addr`  in  `WORD_ADDR_BUS`  branch/jump target.
- `id_exp_code`  in  `DATA_WIDTH_ISA_EXP`  exception code; `ISA_EXP_NO_EXP` = none.
- `mem_busy`  in  1  memory stage not ready; freezes pipeline.
- `if_stall`, `id_stall`  out  1 each  hold PC / IF-ID register.
- `if_flush`  out  1  clear IF-ID register (kill fetched instruction).
- `id_flush`  out  1  insert bubble into ID-EX register.
- `pc_redirect`  out  1  load `new_pc` into PC.
- `new_pc`  out  `WORD_ADDR_BUS`  redirect target.
- `exp_active`  out  1  exception sequence in progress.
- `epc`  out  `WORD_ADDR_BUS`  PC of faulting instruction (registered).
- `exp_cause`  out  `DATA_WIDTH_ISA_EXP`  captured exception code (registered).

## Operation
- State machine: RUN, DRAIN, TRAP. 4-bit down-counter `cnt`. Load tracker regs `ex_ld_valid`, `ex_ld_dst[4:0]`.
- `exc = id_en && id_exp_code != ISA_EXP_NO_EXP`. `lu = ex_ld_valid && id_en && ((id_rs0_used && id_rs0_addr == ex_ld_dst) || (id_rs1_used && id_rs1_addr == ex_ld_dst))`.
- RUN, priority high to low:
  - `mem_busy`: if_stall=id_stall=1; no flush, no redirect; tracker, state, epc held.
  - `lu`: if_stall=id_stall=1, id_flush=1; exception/branch of this instruction ignored this cycle, re-evaluated next cycle.
  - `exc`: id_flush=if_stall=id_stall=1; capture epc<=id_pc, exp_cause<=id_exp_code, cnt<=DRAIN_CYCLES-1; go DRAIN.
  - `id_en && id_br_taken`: pc_redirect=1, new_pc=id_br_addr, if_flush=1.
  - otherwise all controls 0.
- ID advances when RUN, !mem_busy, !lu, !exc. On advance: ex_ld_valid<=id_en && id_mem_load && !id_gpr_we_ && id_dst_addr!=0, ex_ld_dst<=id_dst_addr. Any other non-busy cycle: ex_ld_valid<=0. mem_busy: hold.
- DRAIN: exp_active=1, if_stall=id_stall=id_flush=1. If !mem_busy: cnt==0 -> TRAP, else cnt<=cnt-1. mem_busy freezes cnt. ex_ld_valid<=0.
- TRAP (one cycle, regardless of mem_busy): exp_active=1, pc_redirect=1, new_pc=TRAP_VEC, if_flush=1, id_flush=1; -> RUN.
- new_pc=0 whenever pc_redirect=0.

## Timing
- Stall/flush/redirect outputs combinational from inputs and current state (same cycle). epc, exp_cause, state, tracker update on rising clk.
- Load-use: exactly one bubble per hazard when mem_busy=0; dependent instruction issues the following cycle.
- Exception captured at cycle T: DRAIN T+1..T+DRAIN_CYCLES, TRAP at T+DRAIN_CYCLES+1 (plus one per mem_busy cycle in DRAIN); RUN from T+DRAIN_CYCLES+2.
- Reset (async, any state incl. mid-DRAIN): state=RUN, cnt=0, ex_ld_valid=0, ex_ld_dst=0, epc=0, exp_cause=ISA_EXP_NO_EXP; all 1-bit outputs 0, new_pc=0. First post-reset cycle is plain RUN.
- Load to x0 never creates a hazard. Exception on a stalled (lu) instruction is not captured until the bubble cycle passes.

## Test plan
- Load x5 advances, next ID reads x5 on rs1_used=1 -> one cycle if_stall=id_stall=id_flush=1, then no stall; same with rs reading x6 -> no stall.
- Load to x0 followed by reader of x0 -> no stall.
- id_br_taken=1, id_br_addr=0x40 -> same cycle pc_redirect=1, new_pc=0x40, if_flush=1; with lu true same cycle -> stall only, redirect next cycle.
- id_exp_code=UNDEF_INSN at id_pc=0x12, DRAIN_CYCLES=3 -> epc=0x12, exp_cause=UNDEF next cycle; TRAP redirect to TRAP_VEC 4 cycles after capture; with mem_busy 2 cycles in DRAIN -> 6 cycles.
- mem_busy=1 with taken branch pending -> stalls only, no redirect until mem_busy=0.
- Assert rst during DRAIN -> all outputs 0 immediately, exp_cause=NO_EXP, RUN after release, no trap redirect.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// ID-stage hazard controller bundle: decoded instruction info in,
// stall/flush/redirect and exception status out.
interface pipeline_ctrl_if #(
    parameter int ADDR_W = 30,
    parameter int EXP_W  = 4
);
    logic              id_en;
    logic [ADDR_W-1:0] id_pc;
    logic [4:0]        id_rs0_addr;
    logic [4:0]        id_rs1_addr;
    logic              id_rs0_used;
    logic              id_rs1_used;
    logic [4:0]        id_dst_addr;
    logic              id_gpr_we_;
    logic              id_mem_load;
    logic              id_br_taken;
    logic [ADDR_W-1:0] id_br_addr;
    logic [EXP_W-1:0]  id_exp_code;
    logic              mem_busy;
    logic              if_stall;
    logic              id_stall;
    logic              if_flush;
    logic              id_flush;
    logic              pc_redirect;
    logic [ADDR_W-1:0] new_pc;
    logic              exp_active;
    logic [ADDR_W-1:0] epc;
    logic [EXP_W-1:0]  exp_cause;

    modport master (
        output id_en, id_pc, id_rs0_addr, id_rs1_addr,
        output id_rs0_used, id_rs1_used, id_dst_addr,
        output id_gpr_we_, id_mem_load, id_br_taken,
        output id_br_addr, id_exp_code, mem_busy,
        input  if_stall, id_stall, if_flush, id_flush,
        input  pc_redirect, new_pc, exp_active, epc, exp_cause
    );

    modport slave (
        input  id_en, id_pc, id_rs0_addr, id_rs1_addr,
        input  id_rs0_used, id_rs1_used, id_dst_addr,
        input  id_gpr_we_, id_mem_load, id_br_taken,
        input  id_br_addr, id_exp_code, mem_busy,
        output if_stall, id_stall, if_flush, id_flush,
        output pc_redirect, new_pc, exp_active, epc, exp_cause
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: load-use bubbles, branch redirects,
// and the exception drain-then-trap sequence.
module pipeline_ctrl #(
    parameter int               ADDR_W       = 30,
    parameter int               EXP_W        = 4,
    parameter int               DRAIN_CYCLES = 3,
    parameter logic [ADDR_W-1:0] TRAP_VEC    = '0,
    parameter logic [EXP_W-1:0]  NO_EXP      = '0
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_ld_valid;
    logic [4:0]        r_ld_dst;
    logic [ADDR_W-1:0] r_epc;
    logic [EXP_W-1:0]  r_cause;

    state_t            w_state_nx;
    logic [3:0]        w_cnt_nx;
    logic              w_ld_valid_nx;
    logic [4:0]        w_ld_dst_nx;
    logic              w_cap;
    logic              w_exc;
    logic              w_lu;
    logic              w_rs0_hit;
    logic              w_rs1_hit;

    assign w_exc = bus.id_en && (bus.id_exp_code != NO_EXP);
    assign w_rs0_hit = bus.id_rs0_used && (bus.id_rs0_addr == r_ld_dst);
    assign w_rs1_hit = bus.id_rs1_used && (bus.id_rs1_addr == r_ld_dst);
    assign w_lu = r_ld_valid && bus.id_en && (w_rs0_hit || w_rs1_hit);

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_ld_valid_nx   = r_ld_valid;
        w_ld_dst_nx     = r_ld_dst;
        w_cap           = 1'b0;
        bus.if_stall    = 1'b0;
        bus.id_stall    = 1'b0;
        bus.if_flush    = 1'b0;
        bus.id_flush    = 1'b0;
        bus.pc_redirect = 1'b0;
        bus.new_pc      = '0;
        bus.exp_active  = 1'b0;
        unique case (r_state)
            RUN: begin
                if (bus.mem_busy) begin
                    bus.if_stall = 1'b1;
                    bus.id_stall = 1'b1;
                end else if (w_lu) begin
                    bus.if_stall  = 1'b1;
                    bus.id_stall  = 1'b1;
                    bus.id_flush  = 1'b1;
                    w_ld_valid_nx = 1'b0;
                end else if (w_exc) begin
                    bus.if_stall  = 1'b1;
                    bus.id_stall  = 1'b1;
                    bus.id_flush  = 1'b1;
                    w_ld_valid_nx = 1'b0;
                    w_cap         = 1'b1;
                    w_cnt_nx      = 4'(DRAIN_CYCLES - 1);
                    w_state_nx    = DRAIN;
                end else begin
                    if (bus.id_en && bus.id_br_taken) begin
                        bus.pc_redirect = 1'b1;
                        bus.new_pc      = bus.id_br_addr;
                        bus.if_flush    = 1'b1;
                    end
                    w_ld_valid_nx = bus.id_en && bus.id_mem_load &&
                                    !bus.id_gpr_we_ &&
                                    (bus.id_dst_addr != 5'd0);
                    w_ld_dst_nx   = bus.id_dst_addr;
                end
            end
            DRAIN: begin
                bus.exp_active = 1'b1;
                bus.if_stall   = 1'b1;
                bus.id_stall   = 1'b1;
                bus.id_flush   = 1'b1;
                w_ld_valid_nx  = 1'b0;
                if (!bus.mem_busy) begin
                    if (r_cnt == 4'd0) w_state_nx = TRAP;
                    else               w_cnt_nx   = r_cnt - 4'd1;
                end
            end
            TRAP: begin
                bus.exp_active  = 1'b1;
                bus.pc_redirect = 1'b1;
                bus.new_pc      = TRAP_VEC;
                bus.if_flush    = 1'b1;
                bus.id_flush    = 1'b1;
                w_ld_valid_nx   = 1'b0;
                w_state_nx      = RUN;
            end
            default: w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_cnt      <= 4'd0;
            r_ld_valid <= 1'b0;
            r_ld_dst   <= 5'd0;
            r_epc      <= '0;
            r_cause    <= NO_EXP;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_ld_valid <= w_ld_valid_nx;
            r_ld_dst   <= w_ld_dst_nx;
            if (w_cap) begin
                r_epc   <= bus.id_pc;
                r_cause <= bus.id_exp_code;
            end
        end
    end

    assign bus.epc       = r_epc;
    assign bus.exp_cause = r_cause;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-level
// behavioural model of the hazard/exception rules.
module tb_pipeline_ctrl;
    localparam int          AW    = 30;
    localparam int          EW    = 4;
    localparam int          DRN   = 3;
    localparam logic [29:0] TVEC  = 30'h100;
    localparam logic [3:0]  UNDEF = 4'd1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipeline_ctrl_if #(.ADDR_W(AW), .EXP_W(EW)) bus ();

    pipeline_ctrl #(
        .ADDR_W(AW), .EXP_W(EW), .DRAIN_CYCLES(DRN),
        .TRAP_VEC(TVEC), .NO_EXP(4'd0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {if_stall, id_stall, if_flush, id_flush, pc_redirect, exp_active}
    function automatic logic [5:0] ctrl();
        return {bus.if_stall, bus.id_stall, bus.if_flush,
                bus.id_flush, bus.pc_redirect, bus.exp_active};
    endfunction

    task automatic set_idle();
        bus.id_en       = 1'b0;
        bus.id_pc       = '0;
        bus.id_rs0_addr = '0;
        bus.id_rs1_addr = '0;
        bus.id_rs0_used = 1'b0;
        bus.id_rs1_used = 1'b0;
        bus.id_dst_addr = '0;
        bus.id_gpr_we_  = 1'b1;
        bus.id_mem_load = 1'b0;
        bus.id_br_taken = 1'b0;
        bus.id_br_addr  = '0;
        bus.id_exp_code = '0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic put_load(input logic [4:0] dst);
        set_idle();
        bus.id_en       = 1'b1;
        bus.id_mem_load = 1'b1;
        bus.id_gpr_we_  = 1'b0;
        bus.id_dst_addr = dst;
    endtask

    task automatic put_read(input logic [4:0] r0, input logic u0,
                            input logic [4:0] r1, input logic u1);
        set_idle();
        bus.id_en       = 1'b1;
        bus.id_rs0_addr = r0;
        bus.id_rs0_used = u0;
        bus.id_rs1_addr = r1;
        bus.id_rs1_used = u1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ctrl() !== 6'b0 || bus.new_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b/%h want 000000/0", ctrl(), bus.new_pc);
        end
        n_checks++;
        if (bus.epc !== '0 || bus.exp_cause !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_regs: epc %h cause %h want 0/0", bus.epc, bus.exp_cause);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [5:0] want [6];
        want = '{6'b000000, 6'b110100, 6'b000000,
                 6'b000000, 6'b000000, 6'b110100};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0: put_load(5'd5);
                1: put_read(5'd0, 1'b0, 5'd5, 1'b1);
                2: put_read(5'd0, 1'b0, 5'd5, 1'b1);
                3: put_load(5'd5);
                4: put_read(5'd5, 1'b0, 5'd6, 1'b1);
                default: ;
            endcase
            if (i == 4) begin
                #1;
                n_checks++;
                if (ctrl() !== want[i]) begin
                    n_fail++;
                    $display("FAIL lu_step%0d: got %b want %b", i, ctrl(), want[i]);
                end
                @(negedge clk);
                put_load(5'd5);
                continue;
            end
            if (i == 5) put_read(5'd5, 1'b1, 5'd0, 1'b0);
            #1;
            n_checks++;
            if (ctrl() !== want[i]) begin
                n_fail++;
                $display("FAIL lu_step%0d: got %b want %b", i, ctrl(), want[i]);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_load_x0();
        @(negedge clk);
        put_load(5'd0);
        @(negedge clk);
        put_read(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        n_checks++;
        if (ctrl() !== 6'b0) begin
            n_fail++;
            $display("FAIL load_x0: got %b want 000000", ctrl());
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_idle();
        bus.id_en = 1'b1;
        bus.id_br_taken = 1'b1;
        bus.id_br_addr = 30'h40;
        #1;
        n_checks++;
        if (ctrl() !== 6'b001010 || bus.new_pc !== 30'h40) begin
            n_fail++;
            $display("FAIL branch: got %b/%h want 001010/40", ctrl(), bus.new_pc);
        end
        @(negedge clk);
        put_load(5'd7);
        @(negedge clk);
        put_read(5'd7, 1'b1, 5'd0, 1'b0);
        bus.id_br_taken = 1'b1;
        bus.id_br_addr = 30'h40;
        #1;
        n_checks++;
        if (ctrl() !== 6'b110100 || bus.new_pc !== '0) begin
            n_fail++;
            $display("FAIL branch_lu: got %b/%h want 110100/0", ctrl(), bus.new_pc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ctrl() !== 6'b001010 || bus.new_pc !== 30'h40) begin
            n_fail++;
            $display("FAIL branch_after_lu: got %b/%h want 001010/40", ctrl(), bus.new_pc);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_busy_branch();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            bus.id_en = 1'b1;
            bus.id_br_taken = 1'b1;
            bus.id_br_addr = 30'h40;
            bus.mem_busy = (i < 2);
            #1;
            n_checks++;
            if (i < 2 && (ctrl() !== 6'b110000 || bus.new_pc !== '0)) begin
                n_fail++;
                $display("FAIL busy_branch%0d: got %b/%h want 110000/0", i, ctrl(), bus.new_pc);
            end else if (i == 2 && (ctrl() !== 6'b001010 || bus.new_pc !== 30'h40)) begin
                n_fail++;
                $display("FAIL busy_branch_release: got %b/%h want 001010/40", ctrl(), bus.new_pc);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    // busy_cycles: cycles of mem_busy asserted at the start of DRAIN
    task automatic test_exception(input int busy_cycles);
        int trap_at;
        @(negedge clk);
        set_idle();
        bus.id_en = 1'b1;
        bus.id_pc = 30'h12;
        bus.id_exp_code = UNDEF;
        #1;
        n_checks++;
        if (ctrl() !== 6'b110100) begin
            n_fail++;
            $display("FAIL exc_capture: got %b want 110100", ctrl());
        end
        trap_at = DRN + 1 + busy_cycles;
        for (int k = 1; k <= trap_at + 1; k++) begin
            @(negedge clk);
            set_idle();
            bus.mem_busy = (k <= busy_cycles);
            #1;
            if (k == 1) begin
                n_checks++;
                if (bus.epc !== 30'h12 || bus.exp_cause !== UNDEF) begin
                    n_fail++;
                    $display("FAIL exc_regs: epc %h cause %h want 12/%h", bus.epc, bus.exp_cause, UNDEF);
                end
            end
            n_checks++;
            if (k < trap_at && ctrl() !== 6'b110101) begin
                n_fail++;
                $display("FAIL exc_drain_b%0d_k%0d: got %b want 110101", busy_cycles, k, ctrl());
            end else if (k == trap_at && (ctrl() !== 6'b001111 || bus.new_pc !== TVEC)) begin
                n_fail++;
                $display("FAIL exc_trap_b%0d: got %b/%h want 001111/%h", busy_cycles, ctrl(), bus.new_pc, TVEC);
            end else if (k > trap_at && ctrl() !== 6'b0) begin
                n_fail++;
                $display("FAIL exc_run_b%0d: got %b want 000000", busy_cycles, ctrl());
            end
        end
    endtask

    task automatic test_reset_drain();
        @(negedge clk);
        set_idle();
        bus.id_en = 1'b1;
        bus.id_pc = 30'h33;
        bus.id_exp_code = UNDEF;
        @(negedge clk);
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctrl() !== 6'b0 || bus.new_pc !== '0 || bus.exp_cause !== 4'd0 || bus.epc !== '0) begin
            n_fail++;
            $display("FAIL reset_drain: got %b/%h cause %h epc %h want all 0", ctrl(), bus.new_pc, bus.exp_cause, bus.epc);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DRN + 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (ctrl() !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_drain_run%0d: got %b want 000000", k, ctrl());
            end
        end
    endtask

    task automatic test_random(input int cycles);
        int          m_load;
        int          m_drain;
        bit          m_trap;
        logic [29:0] m_epc;
        logic [3:0]  m_cause;
        logic [5:0]  w_ctrl;
        logic [29:0] w_pc;
        bit          hz;
        m_load = -1;
        m_drain = 0;
        m_trap = 0;
        m_epc = '0;
        m_cause = '0;
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            bus.id_en       = ($urandom_range(0, 9) < 8);
            bus.id_pc       = 30'($urandom);
            bus.id_rs0_addr = 5'($urandom_range(0, 3));
            bus.id_rs1_addr = 5'($urandom_range(0, 3));
            bus.id_rs0_used = 1'($urandom);
            bus.id_rs1_used = 1'($urandom);
            bus.id_dst_addr = 5'($urandom_range(0, 3));
            bus.id_gpr_we_  = ($urandom_range(0, 3) == 0);
            bus.id_mem_load = ($urandom_range(0, 9) < 4);
            bus.id_br_taken = ($urandom_range(0, 4) == 0);
            bus.id_br_addr  = 30'($urandom);
            bus.id_exp_code = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            bus.mem_busy    = ($urandom_range(0, 4) == 0);
            w_pc = '0;
            if (m_trap) begin
                w_ctrl = 6'b001111;
                w_pc = TVEC;
                m_trap = 0;
                m_load = -1;
            end else if (m_drain > 0) begin
                w_ctrl = 6'b110101;
                m_load = -1;
                if (!bus.mem_busy) begin
                    m_drain--;
                    if (m_drain == 0) m_trap = 1;
                end
            end else begin
                hz = (m_load >= 0) && bus.id_en &&
                     ((bus.id_rs0_used && int'(bus.id_rs0_addr) == m_load) ||
                      (bus.id_rs1_used && int'(bus.id_rs1_addr) == m_load));
                if (bus.mem_busy) begin
                    w_ctrl = 6'b110000;
                end else if (hz) begin
                    w_ctrl = 6'b110100;
                    m_load = -1;
                end else if (bus.id_en && bus.id_exp_code != 4'd0) begin
                    w_ctrl = 6'b110100;
                    m_load = -1;
                    m_drain = DRN;
                end else begin
                    w_ctrl = 6'b000000;
                    if (bus.id_en && bus.id_br_taken) begin
                        w_ctrl = 6'b001010;
                        w_pc = bus.id_br_addr;
                    end
                    m_load = (bus.id_en && bus.id_mem_load && !bus.id_gpr_we_ &&
                              bus.id_dst_addr != 0) ? int'(bus.id_dst_addr) : -1;
                end
            end
            #1;
            n_checks++;
            if (ctrl() !== w_ctrl || bus.new_pc !== w_pc) begin
                n_fail++;
                $display("FAIL rand_ctrl c%0d: got %b/%h want %b/%h", c, ctrl(), bus.new_pc, w_ctrl, w_pc);
            end
            n_checks++;
            if (bus.epc !== m_epc || bus.exp_cause !== m_cause) begin
                n_fail++;
                $display("FAIL rand_regs c%0d: got %h/%h want %h/%h", c, bus.epc, bus.exp_cause, m_epc, m_cause);
            end
            if (m_drain == DRN && w_ctrl == 6'b110100 && bus.id_exp_code != 4'd0 &&
                bus.id_en && !bus.mem_busy) begin
                m_epc = bus.id_pc;
                m_cause = bus.id_exp_code;
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_load_x0();
        test_branch();
        test_busy_branch();
        test_exception(0);
        test_exception(2);
        test_reset_drain();
        test_random(1500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
